adder_pipe: RTL and testbench



---
 rtl/adder_pipe.sv | 156 +++++++++++++++
 tb/tb_adder_pipe.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: the carry chain is cut into CHUNK-bit ripple
// segments, one per stage, with a valid/ready handshake and full backpressure.
module adder_pipe #(
    parameter int W     = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [1:0]   op,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         carry_out,
    output logic         overflow,
    output logic         zero,
    output logic         negative
);

    localparam int STAGES = (W + CHUNK - 1) / CHUNK;

    // Ripple only the bits of chunk k; other result bits pass through untouched.
    function automatic logic [W:0] add_chunk(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [W-1:0] res,
                                             input logic         c,
                                             input int           k);
        logic [W-1:0] r;
        logic         cc;
        r  = res;
        cc = c;
        for (int i = 0; i < W; i++) begin
            if (i >= k * CHUNK && i < (k + 1) * CHUNK) begin
                r[i] = a[i] ^ b[i] ^ cc;
                cc   = (a[i] & b[i]) | (cc & (a[i] ^ b[i]));
            end
        end
        return {cc, r};
    endfunction

    logic         vld_q [STAGES];
    logic         vld_d [STAGES];
    logic [W-1:0] res_q [STAGES];
    logic [W-1:0] res_d [STAGES];
    logic         cry_q [STAGES];
    logic         cry_d [STAGES];
    logic [W-1:0] a_q   [STAGES];
    logic [W-1:0] a_d   [STAGES];
    logic [W-1:0] b_q   [STAGES];
    logic [W-1:0] b_d   [STAGES];
    logic         ovf_q, ovf_d;
    logic         zero_q, zero_d;
    logic         neg_q, neg_d;

    logic [STAGES-1:0] load;
    logic              in_fire;
    logic [W-1:0]      sa, sb, sr;
    logic              sc;
    logic [W:0]        sum;

    always_comb begin
        // A stage may load when it is empty or its content moves on this edge.
        load[STAGES-1] = !vld_q[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            load[k] = !vld_q[k] || load[k+1];
        end
        in_ready = !rst && load[0];
        in_fire  = in_valid && in_ready;

        ovf_d  = ovf_q;
        zero_d = zero_q;
        neg_d  = neg_q;
        sa     = '0;
        sb     = '0;
        sr     = '0;
        sc     = 1'b0;
        sum    = '0;

        for (int k = 0; k < STAGES; k++) begin
            vld_d[k] = vld_q[k];
            res_d[k] = res_q[k];
            cry_d[k] = cry_q[k];
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];

            if (k == 0) begin
                sa = x;
                sb = y ^ {W{op[0]}};
                sc = (op == 2'b01) | (op[1] & cin);
                sr = '0;
            end else begin
                sa = a_q[(k > 0) ? k - 1 : 0];
                sb = b_q[(k > 0) ? k - 1 : 0];
                sc = cry_q[(k > 0) ? k - 1 : 0];
                sr = res_q[(k > 0) ? k - 1 : 0];
            end
            sum = add_chunk(sa, sb, sr, sc, k);

            if (load[k]) begin
                vld_d[k] = (k == 0) ? in_fire : vld_q[(k > 0) ? k - 1 : 0];
                res_d[k] = sum[W-1:0];
                cry_d[k] = sum[W];
                a_d[k]   = sa;
                b_d[k]   = sb;
                if (k == STAGES - 1) begin
                    // Carry into the MSB is recovered from its sum bit.
                    ovf_d  = sum[W] ^ (sum[W-1] ^ sa[W-1] ^ sb[W-1]);
                    zero_d = (sum[W-1:0] == '0);
                    neg_d  = sum[W-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                res_q[k] <= '0;
                cry_q[k] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_d[k];
                res_q[k] <= res_d[k];
                cry_q[k] <= cry_d[k];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

    // Operands in flight are pure data and are qualified by the valid bits.
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign result    = res_q[STAGES-1];
    assign carry_out = cry_q[STAGES-1];
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign negative  = neg_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: a 16/4 and a 9/4 instance, each scored against an
// arithmetic reference model, plus literal results for the directed cases.
module tb_adder_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv16, ir16, ov16, or16, ci16, c16, v16, z16, n16;
    logic [15:0] x16, y16, r16;
    logic [1:0]  op16;
    logic        iv9, ir9, ov9, or9, ci9, c9, v9, z9, n9;
    logic [8:0]  x9, y9, r9;
    logic [1:0]  op9;

    adder_pipe #(.W(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .x(x16), .y(y16),
        .op(op16), .cin(ci16), .out_valid(ov16), .out_ready(or16), .result(r16),
        .carry_out(c16), .overflow(v16), .zero(z16), .negative(n16));

    adder_pipe #(.W(9), .CHUNK(4)) dut9 (
        .clk(clk), .rst(rst), .in_valid(iv9), .in_ready(ir9), .x(x9), .y(y9),
        .op(op9), .cin(ci9), .out_valid(ov9), .out_ready(or9), .result(r9),
        .carry_out(c9), .overflow(v9), .zero(z9), .negative(n9));

    typedef struct packed {
        logic [15:0] r;
        logic c, v, z, n;
    } exp_t;

    exp_t q16[$];
    exp_t q9[$];
    int   checks = 0;
    int   errors = 0;
    int   pushed16 = 0, popped16 = 0, pushed9 = 0, popped9 = 0;
    logic held16 = 1'b0, held9 = 1'b0;
    exp_t hold16, hold9;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain W-bit two's-complement arithmetic.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic [1:0] o, input logic ci);
        logic [31:0] mask, bb, aa, s, res;
        logic        c0;
        exp_t        e;
        mask = (32'd1 << w) - 32'd1;
        aa   = {16'd0, a} & mask;
        bb   = (o[0] ? ~{16'd0, b} : {16'd0, b}) & mask;
        c0   = (o == 2'b01) ? 1'b1 : (o[1] ? ci : 1'b0);
        s    = aa + bb + {31'd0, c0};
        res  = s & mask;
        e.r  = res[15:0];
        e.c  = s[w];
        e.n  = res[w-1];
        e.z  = (res == 32'd0);
        e.v  = (aa[w-1] == bb[w-1]) && (res[w-1] != aa[w-1]);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t act, e;
        if (rst) begin
            check("rst_outvalid16", {31'd0, ov16}, 32'd0);
            check("rst_outvalid9", {31'd0, ov9}, 32'd0);
            held16 = 1'b0;
            held9  = 1'b0;
        end else begin
            act = {r16, c16, v16, z16, n16};
            if (ov16) begin
                if (held16) check("hold16", act, hold16);
                if (or16) begin
                    if (q16.size() == 0) check("spurious16", {31'd0, ov16}, 32'd0);
                    else begin
                        e = q16.pop_front();
                        check("model16", act, e);
                        popped16++;
                    end
                    held16 = 1'b0;
                end else begin
                    held16 = 1'b1;
                    hold16 = act;
                end
            end else held16 = 1'b0;
            if (iv16 && ir16) begin
                q16.push_back(model(16, x16, y16, op16, ci16));
                pushed16++;
            end

            act = {7'd0, r9, c9, v9, z9, n9};
            if (ov9) begin
                if (held9) check("hold9", act, hold9);
                if (or9) begin
                    if (q9.size() == 0) check("spurious9", {31'd0, ov9}, 32'd0);
                    else begin
                        e = q9.pop_front();
                        check("model9", act, e);
                        popped9++;
                    end
                    held9 = 1'b0;
                end else begin
                    held9 = 1'b1;
                    hold9 = act;
                end
            end else held9 = 1'b0;
            if (iv9 && ir9) begin
                q9.push_back(model(9, {7'd0, x9}, {7'd0, y9}, op9, ci9));
                pushed9++;
            end
        end
    end

    // Offers one operation and returns 1 ns after the edge that accepts it;
    // in_valid stays high so consecutive calls stream back-to-back.
    task automatic send(input int sel, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] o, input logic ci);
        bit ok;
        ok = 1'b0;
        if (sel == 16) begin
            x16 = a; y16 = b; op16 = o; ci16 = ci; iv16 = 1'b1;
        end else begin
            x9 = a[8:0]; y9 = b[8:0]; op9 = o; ci9 = ci; iv9 = 1'b1;
        end
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if ((sel == 16) ? ir16 : ir9) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", {31'd0, (sel == 16) ? ir16 : ir9}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_lit(input int sel, input string name, input logic [19:0] lit,
                              input int lat);
        int cnt;
        cnt = 0;
        while (!((sel == 16) ? ov16 : ov9) && cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (sel == 16) check(name, {12'd0, r16, c16, v16, z16, n16}, {12'd0, lit});
        else check(name, {12'd0, 7'd0, r9, c9, v9, z9, n9}, {12'd0, lit});
        if (lat >= 0) check({name, "_latency"}, cnt, lat);
        @(posedge clk);
        #1;
    endtask

    task automatic lit16(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] o, input logic ci, input logic [19:0] lit,
                         input int lat);
        send(16, a, b, o, ci);
        iv16 = 1'b0;
        expect_lit(16, name, lit, lat);
    endtask

    bit saw_full;
    bit done16, done9;

    initial begin
        rst = 1'b1;
        iv16 = 0; x16 = 0; y16 = 0; op16 = 0; ci16 = 0; or16 = 1;
        iv9 = 0; x9 = 0; y9 = 0; op9 = 0; ci9 = 0; or9 = 1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state16", {ir16, ov16, c16, v16, z16, n16, r16}, 32'd0);
        check("reset_state9", {ir9, ov9, c9, v9, z9, n9, 7'd0, r9}, 32'd0);
        #2 rst = 1'b0;
        #1 check("inready_after_release", {30'd0, ir16, ir9}, 32'd3);
        @(posedge clk);
        #1;

        lit16("add_00ff_0001", 16'h00FF, 16'h0001, 2'b00, 1'b0, {16'h0100, 4'b0000}, 3);
        lit16("sub_5_5",       16'h0005, 16'h0005, 2'b01, 1'b0, {16'h0000, 4'b1010}, -1);
        lit16("sub_3_5",       16'h0003, 16'h0005, 2'b01, 1'b0, {16'hFFFE, 4'b0001}, -1);
        lit16("add_7fff_1",    16'h7FFF, 16'h0001, 2'b00, 1'b0, {16'h8000, 4'b0101}, -1);
        lit16("add_ffff_1",    16'hFFFF, 16'h0001, 2'b00, 1'b0, {16'h0000, 4'b1010}, -1);
        lit16("sub_8000_1",    16'h8000, 16'h0001, 2'b01, 1'b0, {16'h7FFF, 4'b1100}, -1);
        lit16("adc_1_0_c1",    16'h0001, 16'h0000, 2'b10, 1'b1, {16'h0002, 4'b0000}, -1);
        lit16("sbc_0_0_c0",    16'h0000, 16'h0000, 2'b11, 1'b0, {16'hFFFF, 4'b0001}, -1);

        // Backpressure: 10 back-to-back ops, consumer stalls for cycles 3..8.
        saw_full = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(16, 16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom));
                iv16 = 1'b0;
            end
            begin
                for (int c = 0; c < 14; c++) begin
                    or16 = !(c >= 3 && c <= 8);
                    @(posedge clk);
                    #1;
                    if (!ir16 && !or16) saw_full = 1'b1;
                end
                or16 = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        check("backpressure_inready_fell", {31'd0, saw_full}, 32'd1);
        check("stream_drained", q16.size(), 0);
        check("stream_count", popped16, pushed16);

        // Reset with three operations in flight.
        send(16, 16'h1111, 16'h2222, 2'b00, 1'b0);
        send(16, 16'h3333, 16'h4444, 2'b00, 1'b0);
        send(16, 16'h5555, 16'h6666, 2'b01, 1'b0);
        iv16 = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_outvalid", {31'd0, ov16}, 32'd0);
        check("midrst_result", {16'd0, r16}, 32'd0);
        check("midrst_inready", {31'd0, ir16}, 32'd0);
        q16.delete();
        q9.delete();
        pushed16 = popped16;
        pushed9  = popped9;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check("inready_after_midrst", {31'd0, ir16}, 32'd1);
        repeat (8) @(posedge clk);
        #1;
        check("no_stale_after_rst", popped16, pushed16);

        send(9, 16'h01FF, 16'h0001, 2'b00, 1'b0);
        iv9 = 1'b0;
        expect_lit(9, "w9_add_1ff_001", {16'h0000, 4'b1010}, 2);

        // Randomised traffic on both instances with random consumer stalls.
        done16 = 1'b0;
        done9  = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(16, 16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom));
                    if ($urandom_range(0, 3) == 0) begin
                        iv16 = 1'b0;
                        x16 = 16'($urandom);
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                end
                iv16 = 1'b0;
                done16 = 1'b1;
            end
            begin
                for (int i = 0; i < 200; i++) begin
                    send(9, 16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom));
                    if ($urandom_range(0, 2) == 0) begin
                        iv9 = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                end
                iv9 = 1'b0;
                done9 = 1'b1;
            end
            begin
                for (int c = 0; c < 20000 && !(done16 && done9); c++) begin
                    or16 = ($urandom_range(0, 3) != 0);
                    or9  = ($urandom_range(0, 4) != 0);
                    @(posedge clk);
                    #1;
                end
                or16 = 1'b1;
                or9  = 1'b1;
            end
        join
        repeat (12) @(posedge clk);
        #1;
        check("random_drained16", q16.size(), 0);
        check("random_drained9", q9.size(), 0);
        check("random_count16", popped16, pushed16);
        check("random_count9", popped9, pushed9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
